// File: rtl/eep_pkg.sv
// eep_pkg: shared constants and types for the EEPROM responder slice.
//   EEP_DW, EEP_AW        : word width and address width of the array
//   EEP_RST_W0..W3        : values loaded into the array on reset
//   eep_state_t           : responder FSM states (IDLE, PUMP, DESEL)
package eep_pkg;

    localparam int EEP_DW    = 14;
    localparam int EEP_AW    = 2;
    localparam int EEP_WORDS = 4;

    localparam logic [EEP_DW-1:0] EEP_RST_W0 = 14'h0000;
    localparam logic [EEP_DW-1:0] EEP_RST_W1 = 14'h0000;
    localparam logic [EEP_DW-1:0] EEP_RST_W2 = 14'h0000;
    localparam logic [EEP_DW-1:0] EEP_RST_W3 = 14'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUMP  = 2'd1,
        DESEL = 2'd2
    } eep_state_t;

endpackage

// File: rtl/eep_responder_chrg_pmp_timer.sv
// chrg_pmp_timer: saturating count of charge-pump cycles for a pending write.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count one qualified pump cycle
//   count    : current count, saturates at CHRG_CYCLES
//   done     : count has reached CHRG_CYCLES
module chrg_pmp_timer #(
    parameter int CHRG_CYCLES = 4,
    parameter int CNT_W       = $clog2(CHRG_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHRG_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            // Hold at CNT_MAX so a long pump burst can never wrap to zero.
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == CNT_MAX);

endmodule

// File: rtl/eep_responder.sv
// eep_responder: 4 x 14-bit EEPROM-style word store driven by a core.
// Reads return mem[eep_addr] one cycle after the request. A write latches
// address/data on request, then needs CHRG_CYCLES consecutive pump cycles
// before it commits; any break in the pump sequence aborts it. After a
// commit (or a rejected write) chip select must be released before the
// next request is accepted.
//   clk, rst      : clock, asynchronous active-high reset
//   eep_cs_n      : chip select, active-low
//   eep_r_w_n     : 1 = read, 0 = write
//   eep_addr      : word address 0..3
//   eep_wr_data   : write data
//   chrg_pmp_en   : charge-pump enable from the core
//   eep_rd_data   : registered read data
//   wr_done       : one-cycle pulse on write commit
//   wr_err        : one-cycle pulse on write abort/reject
// Build option: define EEP_WR_PROTECT_EN to make address 3 read-only
// (writes to it are rejected with wr_err).
module eep_responder
    import eep_pkg::*;
#(
    parameter int CHRG_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eep_cs_n,
    input  logic              eep_r_w_n,
    input  logic [EEP_AW-1:0] eep_addr,
    input  logic [EEP_DW-1:0] eep_wr_data,
    input  logic              chrg_pmp_en,
    output logic [EEP_DW-1:0] eep_rd_data,
    output logic              wr_done,
    output logic              wr_err
);

    localparam int CNT_W = $clog2(CHRG_CYCLES + 1);

    eep_state_t        state;
    logic [EEP_AW-1:0] lat_addr;
    logic [EEP_DW-1:0] lat_data;
    logic [EEP_DW-1:0] mem [EEP_WORDS];

    logic [CNT_W-1:0]  pmp_cnt;
    logic              pmp_done;
    logic              pmp_clr;
    logic              pmp_inc;

    logic              rd_req;
    logic              wr_req;
    logic              wr_prot;
    logic              commit;
    logic              pmp_abort;

    assign rd_req = (state == IDLE) && !eep_cs_n &&  eep_r_w_n;
    assign wr_req = (state == IDLE) && !eep_cs_n && !eep_r_w_n;

`ifdef EEP_WR_PROTECT_EN
    assign wr_prot = wr_req && (eep_addr == EEP_AW'(3));
`else
    assign wr_prot = 1'b0;
`endif

    // Completion is checked before abort: once the count is reached the
    // write commits even if the core lets go of the bus on that cycle.
    assign commit = (state == PUMP) && pmp_done;

    // Pump low only aborts after at least one counted cycle, so the core may
    // raise chrg_pmp_en a cycle after issuing the write.
    assign pmp_abort = (state == PUMP) && !pmp_done &&
                       (eep_cs_n || eep_r_w_n ||
                        (!chrg_pmp_en && (pmp_cnt != '0)));

    // Counter is held clear outside PUMP, so it starts from zero on entry.
    assign pmp_clr = (state != PUMP);
    assign pmp_inc = (state == PUMP) && !eep_cs_n && !eep_r_w_n && chrg_pmp_en;

    chrg_pmp_timer #(
        .CHRG_CYCLES (CHRG_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (pmp_clr),
        .inc   (pmp_inc),
        .count (pmp_cnt),
        .done  (pmp_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            eep_rd_data <= '0;
            wr_done     <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        eep_rd_data <= mem[eep_addr];
                    end else if (wr_req) begin
                        if (wr_prot) begin
                            wr_err <= 1'b1;
                            state  <= DESEL;
                        end else begin
                            state  <= PUMP;
                        end
                    end
                end
                PUMP: begin
                    if (commit) begin
                        wr_done <= 1'b1;
                        state   <= DESEL;
                    end else if (pmp_abort) begin
                        wr_err  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                DESEL: begin
                    if (eep_cs_n) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write target is captured once on request; later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (wr_req) begin
            lat_addr <= eep_addr;
            lat_data <= eep_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= EEP_RST_W0;
            mem[1] <= EEP_RST_W1;
            mem[2] <= EEP_RST_W2;
            mem[3] <= EEP_RST_W3;
        end else if (commit) begin
            mem[lat_addr] <= lat_data;
        end
    end

endmodule
